// File: rtl/kamus_lsu_if.sv
// L1D request/response bus between the kamus-v load-store unit and the data cache.
interface kamus_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              gnt;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/kamus_lsu.sv
// kamus-v MEM-stage load-store unit: one outstanding L1D access, store lane
// alignment, load extension, and misalignment/timeout error reporting.
module kamus_lsu #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_addr_i,
  output logic              resp_valid_o,
  output logic              resp_load_o,
  output logic [31:0]       resp_rdata_o,
  output logic [4:0]        resp_rd_addr_o,
  output logic              err_valid_o,
  output logic [1:0]        err_cause_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              busy_o,
  kamus_lsu_if.master       dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

  localparam int         CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam bit         TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;

  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_load_q, resp_load_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_cause_q, err_cause_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              misalign;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       lane_word;
  logic [31:0]       ld_data;
  logic              expired;

  always_comb begin
    misalign  = 1'b0;
    be_new    = 4'b0000;
    wdata_new = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be_new    = 4'b0001 << req_addr_i[1:0];
        wdata_new = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misalign  = req_addr_i[0];
        be_new    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        misalign = |req_addr_i[1:0];
        be_new   = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  // Legal halves/words are naturally aligned, so shifting the raw word down
  // by the byte offset always leaves the addressed lane in the low bits.
  always_comb begin
    lane_word = dmem.rdata >> {addr_q[1:0], 3'b000};
    ld_data   = lane_word;
    case (size_q)
      2'b00:   ld_data = unsigned_q ? {24'b0, lane_word[7:0]}
                                    : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   ld_data = unsigned_q ? {16'b0, lane_word[15:0]}
                                    : {{16{lane_word[15]}}, lane_word[15:0]};
      default: ld_data = lane_word;
    endcase
  end

  assign expired = TO_EN && (cnt_q == CNT_MAX);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_valid_d = 1'b0;
    resp_load_d  = resp_load_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    err_valid_d  = 1'b0;
    err_cause_d  = err_cause_q;
    err_addr_d   = err_addr_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          addr_d     = req_addr_i;
          rd_d       = req_rd_addr_i;
          dmem_we_d  = req_we_i;
          if (misalign) begin
            err_valid_d = 1'b1;
            err_cause_d = 2'b01;
            err_addr_d  = req_addr_i;
          end else begin
            state_d      = REQ;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_be_d    = be_new;
            dmem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
            dmem_wdata_d = wdata_new;
          end
        end
      end
      REQ: begin
        // Grant is checked before expiry so a last-cycle grant still completes.
        if (dmem.gnt) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_load_d  = 1'b0;
            resp_rdata_d = '0;
            resp_rd_d    = rd_q;
          end else begin
            state_d = WAIT_R;
            cnt_d   = '0;
          end
        end else if (expired) begin
          state_d     = IDLE;
          dmem_req_d  = 1'b0;
          err_valid_d = 1'b1;
          err_cause_d = 2'b10;
          err_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_R: begin
        if (dmem.rvalid) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_load_d  = 1'b1;
          resp_rdata_d = ld_data;
          resp_rd_d    = rd_q;
        end else if (expired) begin
          state_d     = IDLE;
          err_valid_d = 1'b1;
          err_cause_d = 2'b10;
          err_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      rd_q         <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_load_q  <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      err_valid_q  <= 1'b0;
      err_cause_q  <= '0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_load_q  <= resp_load_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      err_valid_q  <= err_valid_d;
      err_cause_q  <= err_cause_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign busy_o         = !req_ready_o;
  assign resp_valid_o   = resp_valid_q;
  assign resp_load_o    = resp_load_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_rd_addr_o = resp_rd_q;
  assign err_valid_o    = err_valid_q;
  assign err_cause_o    = err_cause_q;
  assign err_addr_o     = err_addr_q;
  assign dmem.req       = dmem_req_q;
  assign dmem.we        = dmem_we_q;
  assign dmem.be        = dmem_be_q;
  assign dmem.addr      = dmem_addr_q;
  assign dmem.wdata     = dmem_wdata_q;

endmodule

// File: tb/tb_kamus_lsu.sv
// Directed bench for kamus_lsu with TIMEOUT_CYC = 4: inputs change 1ns after
// the rising edge, outputs are sampled on the falling edge.
module tb_kamus_lsu;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_addr_i;
  logic        resp_valid_o;
  logic        resp_load_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_addr_o;
  logic        err_valid_o;
  logic [1:0]  err_cause_o;
  logic [31:0] err_addr_o;
  logic        busy_o;

  int nVectors = 0;
  int nErrors  = 0;

  kamus_lsu_if #(.ADDR_W(32)) dmem ();

  kamus_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_rd_addr_i  (req_rd_addr_i),
    .resp_valid_o   (resp_valid_o),
    .resp_load_o    (resp_load_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_rd_addr_o (resp_rd_addr_o),
    .err_valid_o    (err_valid_o),
    .err_cause_o    (err_cause_o),
    .err_addr_o     (err_addr_o),
    .busy_o         (busy_o),
    .dmem           (dmem)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_rd_addr_i  = rd;
  endtask

  // Load with immediate grant and rvalid the cycle after grant.
  task automatic runLoad(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [3:0] expBe, input logic [31:0] expData);
    nextCycle();
    applyStimulus(1'b0, size, uns, addr, 32'h0, rd);
    sample();
    checkOutput("ld_ready_c0", req_ready_o, 1);
    nextCycle();
    req_valid_i = 1'b0;
    dmem.gnt    = 1'b1;
    sample();
    checkOutput("ld_dmem_req_c1", dmem.req, 1);
    checkOutput("ld_be_c1", dmem.be, expBe);
    checkOutput("ld_addr_c1", dmem.addr, addr & 32'hFFFF_FFFC);
    checkOutput("ld_busy_c1", busy_o, 1);
    nextCycle();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = rdata;
    sample();
    checkOutput("ld_dmem_req_c2", dmem.req, 0);
    checkOutput("ld_resp_c2", resp_valid_o, 0);
    nextCycle();
    dmem.rvalid = 1'b0;
    sample();
    checkOutput("ld_resp_c3", resp_valid_o, 1);
    checkOutput("ld_load_c3", resp_load_o, 1);
    checkOutput("ld_rdata_c3", resp_rdata_o, expData);
    checkOutput("ld_rd_c3", resp_rd_addr_o, rd);
    nextCycle();
    sample();
    checkOutput("ld_resp_c4", resp_valid_o, 0);
    checkOutput("ld_rdata_hold", resp_rdata_o, expData);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni         = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0;
    req_wdata_i    = 32'h0;
    req_rd_addr_i  = 5'd0;
    dmem.gnt       = 1'b0;
    dmem.rvalid    = 1'b0;
    dmem.rdata     = 32'h0;

    #3;
    checkOutput("rst_ready", req_ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_dmem_req", dmem.req, 0);
    checkOutput("rst_resp", resp_valid_o, 0);
    checkOutput("rst_err", err_valid_o, 0);
    nextCycle();
    rst_ni = 1'b1;

    // LB 0x103: lane 3 = 0x80 -> sign-extended / zero-extended
    runLoad(2'b00, 1'b0, 32'h0000_0103, 32'h80FF_1234, 5'd5, 4'b1000, 32'hFFFF_FF80);
    runLoad(2'b00, 1'b1, 32'h0000_0103, 32'h80FF_1234, 5'd6, 4'b1000, 32'h0000_0080);
    // LHU 0x102: upper half
    runLoad(2'b01, 1'b1, 32'h0000_0102, 32'h80FF_1234, 5'd7, 4'b1100, 32'h0000_80FF);

    // SH 0x202 with grant delayed 3 cycles; grant lands on the last counter cycle
    nextCycle();
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd0);
    sample();
    nextCycle();
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("sh_req_wait", dmem.req, 1);
      checkOutput("sh_addr_wait", dmem.addr, 32'h0000_0200);
      checkOutput("sh_be_wait", dmem.be, 4'b1100);
      checkOutput("sh_wdata_wait", dmem.wdata, 32'hABCD_ABCD);
      checkOutput("sh_we_wait", dmem.we, 1);
      nextCycle();
    end
    dmem.gnt = 1'b1;
    sample();
    checkOutput("sh_req_gnt", dmem.req, 1);
    nextCycle();
    dmem.gnt = 1'b0;
    sample();
    checkOutput("sh_resp", resp_valid_o, 1);
    checkOutput("sh_resp_load", resp_load_o, 0);
    checkOutput("sh_resp_rdata", resp_rdata_o, 32'h0);
    checkOutput("sh_err", err_valid_o, 0);

    // SB 0x001: byte lane 1, replicated data
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_565A, 5'd0);
    nextCycle();
    req_valid_i = 1'b0;
    dmem.gnt    = 1'b1;
    sample();
    checkOutput("sb_be", dmem.be, 4'b0010);
    checkOutput("sb_wdata", dmem.wdata, 32'h5A5A_5A5A);
    checkOutput("sb_addr", dmem.addr, 32'h0);
    nextCycle();
    dmem.gnt = 1'b0;
    sample();
    checkOutput("sb_resp", resp_valid_o, 1);

    // Misaligned LW then illegal size accepted during the error cycle
    nextCycle();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd9);
    nextCycle();
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0, 5'd9);
    sample();
    checkOutput("mis_err", err_valid_o, 1);
    checkOutput("mis_cause", err_cause_o, 2'b01);
    checkOutput("mis_addr", err_addr_o, 32'h0000_0101);
    checkOutput("mis_dmem_req", dmem.req, 0);
    checkOutput("mis_ready", req_ready_o, 1);
    checkOutput("mis_resp", resp_valid_o, 0);
    nextCycle();
    req_valid_i = 1'b0;
    sample();
    checkOutput("ill_err", err_valid_o, 1);
    checkOutput("ill_cause", err_cause_o, 2'b01);
    checkOutput("ill_addr", err_addr_o, 32'h0000_0104);
    checkOutput("ill_dmem_req", dmem.req, 0);
    nextCycle();
    sample();
    checkOutput("ill_err_end", err_valid_o, 0);

    // Timeout: grant never comes, 4 REQ cycles then cause 10
    nextCycle();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd4);
    nextCycle();
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      checkOutput("to_req_held", dmem.req, 1);
      checkOutput("to_no_err", err_valid_o, 0);
      nextCycle();
    end
    sample();
    checkOutput("to_err", err_valid_o, 1);
    checkOutput("to_cause", err_cause_o, 2'b10);
    checkOutput("to_addr", err_addr_o, 32'h0000_0300);
    checkOutput("to_dmem_req", dmem.req, 0);
    checkOutput("to_ready", req_ready_o, 1);
    nextCycle();
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'hCAFE_F00D;
    sample();
    checkOutput("to_err_end", err_valid_o, 0);
    checkOutput("to_cause_hold", err_cause_o, 2'b10);
    nextCycle();
    dmem.rvalid = 1'b0;
    sample();
    checkOutput("late_rvalid_resp", resp_valid_o, 0);
    checkOutput("late_rvalid_ready", req_ready_o, 1);

    // Back-to-back LW / SW / LH, new request in each response cycle
    nextCycle();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd1);
    nextCycle();
    req_valid_i = 1'b0;
    dmem.gnt    = 1'b1;
    sample();
    checkOutput("b2b_busy_req", busy_o, 1);
    nextCycle();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h1234_5678;
    sample();
    checkOutput("b2b_busy_wait", busy_o, 1);
    nextCycle();
    dmem.rvalid = 1'b0;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 5'd0);
    sample();
    checkOutput("b2b_lw_resp", resp_valid_o, 1);
    checkOutput("b2b_lw_data", resp_rdata_o, 32'h1234_5678);
    checkOutput("b2b_lw_rd", resp_rd_addr_o, 5'd1);
    checkOutput("b2b_lw_ready", req_ready_o, 1);
    nextCycle();
    req_valid_i = 1'b0;
    dmem.gnt    = 1'b1;
    sample();
    checkOutput("b2b_sw_req", dmem.req, 1);
    checkOutput("b2b_sw_we", dmem.we, 1);
    checkOutput("b2b_sw_be", dmem.be, 4'b1111);
    checkOutput("b2b_sw_wdata", dmem.wdata, 32'hDEAD_BEEF);
    checkOutput("b2b_sw_addr", dmem.addr, 32'h0000_0404);
    nextCycle();
    dmem.gnt = 1'b0;
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0406, 32'h0, 5'd3);
    sample();
    checkOutput("b2b_sw_resp", resp_valid_o, 1);
    checkOutput("b2b_sw_load", resp_load_o, 0);
    checkOutput("b2b_sw_ready", req_ready_o, 1);
    nextCycle();
    req_valid_i = 1'b0;
    dmem.gnt    = 1'b1;
    sample();
    checkOutput("b2b_lh_be", dmem.be, 4'b1100);
    checkOutput("b2b_lh_busy", busy_o, 1);
    nextCycle();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h8001_7FFF;
    nextCycle();
    dmem.rvalid = 1'b0;
    sample();
    checkOutput("b2b_lh_resp", resp_valid_o, 1);
    checkOutput("b2b_lh_load", resp_load_o, 1);
    checkOutput("b2b_lh_data", resp_rdata_o, 32'hFFFF_8001);
    checkOutput("b2b_lh_rd", resp_rd_addr_o, 5'd3);

    // Reset asserted while waiting for rvalid
    nextCycle();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd8);
    nextCycle();
    req_valid_i = 1'b0;
    dmem.gnt    = 1'b1;
    nextCycle();
    dmem.gnt = 1'b0;
    sample();
    checkOutput("rstw_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rstw_ready", req_ready_o, 1);
    checkOutput("rstw_dmem_req", dmem.req, 0);
    checkOutput("rstw_resp", resp_valid_o, 0);
    checkOutput("rstw_rdata", resp_rdata_o, 32'h0);
    nextCycle();
    rst_ni = 1'b1;
    nextCycle();
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h5555_AAAA;
    sample();
    checkOutput("rstw_post_ready", req_ready_o, 1);
    nextCycle();
    dmem.rvalid = 1'b0;
    sample();
    checkOutput("rstw_no_stale", resp_valid_o, 0);
    checkOutput("rstw_no_err", err_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
    $finish;
  end

endmodule

// File: doc/kamus_lsu.md
# kamus_lsu

Parametrised load-store unit for the kamus-v MEM stage: accepts one load/store per handshake from EX and drives the L1D over a req/gnt/rvalid protocol with byte enables. It aligns store data and sign/zero-extends load data. Misaligned or illegal accesses and memory timeouts are reported as errors instead of being issued. It sits between the EX/MEM register and the MEM/WB register and stalls the pipeline while a transaction is outstanding.

## Interface
- ADDR_W, 32, byte-address width of the request and L1D address.
- TIMEOUT_CYC, 0, maximum cycles waited for `dmem_gnt_i` or for `dmem_rvalid_i`; 0 disables the timeout.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  EX presents a memory operation.
- req_ready_o  out  1  LSU idle; the request is accepted when valid && ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend load (LBU/LHU).
- req_addr_i  in  ADDR_W  byte address (ALU result).
- req_wdata_i  in  32  rs2 data for stores.
- req_rd_addr_i  in  5  load destination register.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_load_o  out  1  completed operation was a load; this is the regfile write enable.
- resp_rdata_o  out  32  extended load data; 0 for stores.
- resp_rd_addr_o  out  5  destination register of the completed load.
- err_valid_o  out  1  one-cycle error pulse.
- err_cause_o  out  2  01 misaligned/illegal size, 10 timeout.
- err_addr_o  out  ADDR_W  faulting byte address.
- busy_o  out  1  pipeline stall request (= !req_ready_o).
- dmem_req_o  out  1  L1D request.
- dmem_gnt_i  in  1  L1D accepts request.
- dmem_we_o  out  1  L1D write.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  raw load word.

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- IDLE: `req_ready_o` = 1.
  - Acceptance registers we/size/unsigned/addr/wdata/rd.
  - Legal access: go to REQ.
  - Misaligned or illegal access (half with addr[0] = 1, word with addr[1:0] != 0, size 11): stay in IDLE and pulse `err_valid_o` with cause 01 next cycle. No L1D access and no `resp_valid_o`.
- REQ: `dmem_req_o` = 1. All `dmem_*` outputs come only from registers and are stable until grant.
  - On `dmem_gnt_i`, store: go to IDLE and pulse `resp_valid_o` next cycle with `resp_load_o` = 0.
  - On `dmem_gnt_i`, load: go to WAIT_R.
- WAIT_R: on `dmem_rvalid_i`, register the extracted data, go to IDLE, and pulse `resp_valid_o` with `resp_load_o` = 1 next cycle.
- Byte enables and store data by size:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111; wdata as given.
- Load extract: the lane is selected by addr[1:0]; the result is sign-extended unless `req_unsigned_i` = 1, in which case it is zero-extended.
- Timeout (TIMEOUT_CYC > 0): a cycle counter clears on entry to REQ and on entry to WAIT_R. If the counter reaches TIMEOUT_CYC without gnt/rvalid, go to IDLE, drop `dmem_req_o`, and pulse `err_valid_o` with cause 10. A late `dmem_rvalid_i` arriving in IDLE is ignored.
- Reset (any time, including mid-transaction): state IDLE, counter 0, all registered outputs 0. `dmem_req_o` drops asynchronously and `req_ready_o` = 1 once in reset.

## Timing
- `resp_*`, `err_*`, and `dmem_*` are registered. `req_ready_o` and `busy_o` decode the state combinationally.
- Minimum load latency: accept at cycle 0, `dmem_req_o` at cycle 1 (gnt at 1), rvalid at 2, `resp_valid_o` at 3.
- Minimum store latency: accept at 0, gnt at 1, `resp_valid_o` at 2.
- Misaligned access: accept at 0, `err_valid_o` at 1, `req_ready_o` stays 1.
- A new request may be accepted in the same cycle `resp_valid_o` or `err_valid_o` is high.
- `dmem_rvalid_i` in the grant cycle is not legal; the earliest accepted rvalid is the cycle after gnt.
- Simultaneous gnt and timeout expiry: gnt wins.
- Outputs `resp_*`/`err_*` hold their last values after a pulse ends; only the valid bits return to 0.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234 → be 1000 on `dmem_be_o`, resp_rdata 0xFFFF_FF80 at cycle 3; LBU with the same stimulus → 0x0000_0080.
- SH at addr 0x202, wdata 0x0000_ABCD → dmem_addr 0x200, be 1100, wdata 0xABCD_ABCD, gnt delayed 3 cycles with `dmem_req_o` held stable, `resp_valid_o` with `resp_load_o` = 0 the cycle after gnt.
- LW at addr 0x101 → no `dmem_req_o`, err cause 01 with err_addr 0x101 at cycle 1; size 11 → same error.
- TIMEOUT_CYC = 4, load with gnt never asserted → err cause 10 after 4 REQ cycles, back to IDLE; a late rvalid afterwards produces no response.
- Back-to-back LW/SW/LH with immediate gnt and rvalid → responses in order, a new request accepted in each response cycle, `busy_o` tracks the state.
- `rst_ni` low while in WAIT_R → `dmem_req_o`/`resp_valid_o` 0 immediately, `req_ready_o` = 1, no stale response after release.
